fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS32 datapath. It owns the program counter, issues one instruction-memory request at a time, and registers the returned instruction together with its PC and PC+4 for the decode stage. The sequential PC+4 comes from the shared `adder` module, instantiated internally with WITHD = WIDTH. Later stages can redirect fetch to a branch or jump target at any time.

## Interface
Parameters:
- WIDTH, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  WIDTH  target address; bits [1:0] are ignored and forced to 0.
- imem_req  output  1  request to instruction memory.
- imem_addr  output  WIDTH  request address, equal to the PC register.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; occurs at least 1 cycle after gnt.
- imem_rdata  input  WIDTH  instruction word.
- out_valid  output  1  instruction bundle valid to decode.
- out_ready  input  1  decode accepts the bundle.
- out_pc  output  WIDTH  PC of the presented instruction.
- out_pc4  output  WIDTH  out_pc + 4.
- out_instr  output  WIDTH  presented instruction.

## Operation
- State register: IDLE, REQ, WAIT, OUT. A separate drop flag marks an outstanding response that must be discarded.
- Reset (async, any state): state = IDLE, pc = RESET_PC, drop = 0, out_valid = 0, out_pc/out_pc4/out_instr = 0. imem_req = 0 and imem_addr = RESET_PC.
- IDLE: always go to REQ on the next cycle. Redirect in IDLE loads pc.
- REQ: imem_req = 1 and imem_addr = pc.
  - imem_gnt = 1: go to WAIT.
  - redirect_valid and gnt = 0: pc = redirect_pc, stay in REQ. The next cycle requests the new address.
  - redirect_valid and gnt = 1 together: go to WAIT with drop = 1, pc = redirect_pc.
- WAIT: imem_req = 0.
  - rvalid with drop = 0: capture out_instr = imem_rdata, out_pc = pc, out_pc4 = pc+4; set out_valid = 1; go to OUT.
  - rvalid with drop = 1: discard the data, clear drop, go to REQ.
  - redirect_valid in WAIT: pc = redirect_pc, drop = 1. A redirect in the same cycle as rvalid discards that data and goes to REQ.
- OUT: out_valid = 1; the bundle stays stable while out_ready = 0.
  - out_ready = 1 and no redirect: pc = pc+4, out_valid = 0, go to REQ.
  - redirect_valid: pc = redirect_pc, out_valid = 0, go to REQ. This holds whether or not out_ready is high; redirect wins.
- Arithmetic: pc+4 is computed modulo 2^WIDTH, so 0xFFFF_FFFC wraps to 0x0000_0000. No carry-out is kept.
- At most one memory request is outstanding. imem_gnt and imem_rvalid outside REQ and WAIT respectively are ignored.

## Timing
- Cycle 0 is the first edge after rst deasserts: IDLE. Cycle 1: REQ with imem_addr = RESET_PC.
- Latency: if rvalid arrives in cycle N, out_valid = 1 from cycle N+1.
- Best-case issue rate is one instruction per 3 cycles (REQ → WAIT → OUT) when gnt, rvalid and out_ready are immediate.
- All outputs are registered or decoded from state and pc only. There is no combinational path from inputs to outputs.
- A redirect takes effect at the next edge. The first request to the target is issued in the cycle after the redirect, or later if a dropped response is still pending.
- Reset asserted mid-transaction aborts it immediately. A late rvalid after reset is ignored because the block is not in WAIT.

## Test plan
- Reset/boot, RESET_PC = 0x0040_0000: gnt and rvalid each 1 cycle after request, out_ready = 1. Required: imem_addr sequence 0x00400000, 0x00400004, 0x00400008; out_pc4 = out_pc + 4 for every bundle.
- Backpressure: out_ready = 0 for 5 cycles with out_valid = 1. Required: out_pc, out_pc4 and out_instr stay stable; no imem_req during the stall.
- Redirect in WAIT: redirect_pc = 0x0000_0100 while a request to 0x20 is outstanding. Required: the response for 0x20 never appears on out_valid; the next imem_addr is 0x100.
- Redirect together with gnt in REQ, and redirect together with out_ready in OUT. Required: the target is fetched next and no stale bundle is delivered; redirect_pc = 0x0000_0103 fetches 0x100.
- Wrap-around: RESET_PC = 0xFFFF_FFFC. Required: first out_pc4 = 0x0000_0000 and the second fetch address is 0x0000_0000.
- Async reset asserted during WAIT, then a late rvalid. Required: outputs return to reset values immediately and the late data is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the MIPS32 datapath, plus the shared adder that
// produces the sequential PC+4. The fetch stage keeps one memory request in
// flight, registers the returned instruction with its PC and PC+4, and
// accepts branch/jump redirects in every state.

module adder #(
  parameter int WITHD = 32
) (
  input  logic [WITHD-1:0] a,
  input  logic [WITHD-1:0] b,
  output logic [WITHD-1:0] sum
);

  // Modulo-2^WITHD sum; the carry-out is intentionally dropped.
  assign sum = a + b;

endmodule

module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc4,
  output logic [WIDTH-1:0] out_instr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] redirect_target;
  // Set when the in-flight response belongs to an abandoned fetch address.
  logic             drop;

  adder #(
    .WITHD (WIDTH)
  ) u_pc_adder (
    .a   (pc),
    .b   (WIDTH'(4)),
    .sum (pc_plus4)
  );

  // Targets are forced to word alignment by clearing the two low bits.
  assign redirect_target = redirect_pc & ~WIDTH'(3);

  // Memory interface is decoded from state and pc only, never from inputs.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  // Fetch control: state, pc, drop flag and the registered decode bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_pc4   <= '0;
      out_instr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_target;
          end
          state <= S_REQ;
        end

        S_REQ: begin
          if (imem_gnt) begin
            state <= S_WAIT;
            // Request to the old pc is already accepted; its reply is stale.
            if (redirect_valid) begin
              pc   <= redirect_target;
              drop <= 1'b1;
            end
          end else if (redirect_valid) begin
            pc <= redirect_target;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (imem_rvalid) begin
              // Reply arriving with the redirect is consumed and discarded.
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              out_instr <= imem_rdata;
              out_pc    <= pc;
              out_pc4   <= pc_plus4;
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
          end
        end

        S_OUT: begin
          // Redirect takes priority over a normal handshake.
          if (redirect_valid) begin
            pc        <= redirect_target;
            out_valid <= 1'b0;
            state     <= S_REQ;
          end else if (out_ready) begin
            pc        <= pc_plus4;
            out_valid <= 1'b0;
            state     <= S_REQ;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table for the main
// instance, then hand-written async-reset and PC wrap-around sequences.

module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, RESET_PC = 0x0040_0000
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_pc4, out_instr;

  // Wrap-around instance, RESET_PC = 0xFFFF_FFFC
  logic        w_rst = 1'b1;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_gnt = 1'b0;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_ov;
  logic        w_ready = 1'b0;
  logic [31:0] w_pc, w_pc4, w_instr;

  fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .out_instr      (out_instr)
  );

  fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_gnt       (w_gnt),
    .imem_rvalid    (w_rvalid),
    .imem_rdata     (w_rdata),
    .out_valid      (w_ov),
    .out_ready      (w_ready),
    .out_pc         (w_pc),
    .out_pc4        (w_pc4),
    .out_instr      (w_instr)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic g, input logic rvl, input logic [31:0] rd,
                     input logic rdy, input logic er, input logic [31:0] ea,
                     input logic eo, input logic [31:0] ep, input logic [31:0] ep4,
                     input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.gnt = g; v.rvalid = rvl; v.rdata = rd;
    v.ready = rdy; v.e_req = er; v.e_addr = ea; v.e_ov = eo; v.e_pc = ep;
    v.e_pc4 = ep4; v.e_instr = ei;
    tbl.push_back(v);
  endtask

  initial begin
    //   rst rv rpc      gnt rvl rdata     rdy  req addr      ov pc        pc4       instr
    add(1, 0, 32'h0,    0, 0, 32'h0,     0,   0, 32'h400000, 0, 32'h0,    32'h0,    32'h0);        // 0 reset
    add(0, 0, 32'h0,    0, 0, 32'h0,     0,   1, 32'h400000, 0, 0, 0, 0);                           // 1 REQ
    add(0, 0, 32'h0,    0, 0, 32'h0,     0,   1, 32'h400000, 0, 0, 0, 0);                           // 2 no gnt
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h400000, 0, 0, 0, 0);                           // 3 WAIT
    add(0, 0, 32'h0,    0, 0, 32'h0,     0,   0, 32'h400000, 0, 0, 0, 0);                           // 4 still WAIT
    add(0, 0, 32'h0,    0, 1, 32'h11110000, 0, 0, 32'h400000, 1, 32'h400000, 32'h400004, 32'h11110000); // 5 OUT
    add(0, 0, 32'h0,    0, 0, 32'h0,     1,   1, 32'h400004, 0, 0, 0, 0);                           // 6
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h400004, 0, 0, 0, 0);                           // 7
    add(0, 0, 32'h0,    0, 1, 32'h22220000, 0, 0, 32'h400004, 1, 32'h400004, 32'h400008, 32'h22220000); // 8
    add(0, 0, 32'h0,    0, 0, 32'h0,     1,   1, 32'h400008, 0, 0, 0, 0);                           // 9
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h400008, 0, 0, 0, 0);                           // 10
    add(0, 0, 32'h0,    0, 1, 32'h33330000, 0, 0, 32'h400008, 1, 32'h400008, 32'h40000C, 32'h33330000); // 11
    // backpressure: 5 stall cycles with noise on gnt/rvalid/rdata
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,  1, 1, 32'hEEEE0000 + i, 0, 0, 32'h400008, 1, 32'h400008, 32'h40000C, 32'h33330000);
    add(0, 0, 32'h0,    0, 0, 32'h0,     1,   1, 32'h40000C, 0, 0, 0, 0);                           // 17
    add(0, 1, 32'h20,   0, 0, 32'h0,     0,   1, 32'h20,     0, 0, 0, 0);                           // 18 redirect in REQ
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h20,     0, 0, 0, 0);                           // 19
    add(0, 1, 32'h100,  0, 0, 32'h0,     0,   0, 32'h100,    0, 0, 0, 0);                           // 20 redirect in WAIT
    add(0, 0, 32'h0,    0, 1, 32'hDEAD0020, 0, 1, 32'h100,   0, 0, 0, 0);                           // 21 dropped
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h100,    0, 0, 0, 0);                           // 22
    add(0, 0, 32'h0,    0, 1, 32'h44440100, 0, 0, 32'h100,   1, 32'h100, 32'h104, 32'h44440100);    // 23
    add(0, 1, 32'h200,  0, 0, 32'h0,     1,   1, 32'h200,    0, 0, 0, 0);                           // 24 redirect+ready
    add(0, 1, 32'h103,  1, 0, 32'h0,     0,   0, 32'h100,    0, 0, 0, 0);                           // 25 redirect+gnt
    add(0, 0, 32'h0,    0, 1, 32'hBAD00200, 0, 1, 32'h100,   0, 0, 0, 0);                           // 26 dropped
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h100,    0, 0, 0, 0);                           // 27
    add(0, 0, 32'h0,    0, 1, 32'h55550100, 0, 0, 32'h100,   1, 32'h100, 32'h104, 32'h55550100);    // 28
    add(0, 1, 32'h300,  0, 0, 32'h0,     0,   1, 32'h300,    0, 0, 0, 0);                           // 29 redirect, not ready
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h300,    0, 0, 0, 0);                           // 30
    add(0, 1, 32'h400,  0, 1, 32'hBAD00300, 0, 1, 32'h400,   0, 0, 0, 0);                           // 31 redirect+rvalid
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h400,    0, 0, 0, 0);                           // 32
    add(0, 0, 32'h0,    0, 1, 32'h66660400, 0, 0, 32'h400,   1, 32'h400, 32'h404, 32'h66660400);    // 33
    add(0, 0, 32'h0,    0, 0, 32'h0,     1,   1, 32'h404,    0, 0, 0, 0);                           // 34
    add(0, 0, 32'h0,    1, 0, 32'h0,     0,   0, 32'h404,    0, 0, 0, 0);                           // 35 WAIT

    #1;
    foreach (tbl[i]) begin
      rst            = tbl[i].rst;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      imem_gnt       = tbl[i].gnt;
      imem_rvalid    = tbl[i].rvalid;
      imem_rdata     = tbl[i].rdata;
      out_ready      = tbl[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d req", i),   {31'b0, imem_req},  {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d addr", i),  imem_addr,           tbl[i].e_addr);
      chk($sformatf("v%0d valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
      if (tbl[i].e_ov || tbl[i].rst) begin
        chk($sformatf("v%0d pc", i),    out_pc,    tbl[i].e_pc);
        chk($sformatf("v%0d pc4", i),   out_pc4,   tbl[i].e_pc4);
        chk($sformatf("v%0d instr", i), out_instr, tbl[i].e_instr);
      end
    end

    // Async reset mid-WAIT, then late rvalid while in/after reset
    redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; out_ready = 0;
    #2 rst = 1;
    #1;
    chk("arst req",   {31'b0, imem_req},  32'h0);
    chk("arst addr",  imem_addr,           32'h400000);
    chk("arst valid", {31'b0, out_valid}, 32'h0);
    chk("arst pc",    out_pc,              32'h0);
    chk("arst pc4",   out_pc4,             32'h0);
    chk("arst instr", out_instr,           32'h0);
    imem_rvalid = 1; imem_rdata = 32'h77770000;
    @(posedge clk); #1;
    chk("arst hold valid", {31'b0, out_valid}, 32'h0);
    chk("arst hold req",   {31'b0, imem_req},  32'h0);
    #2 rst = 0;
    @(posedge clk); #1;
    chk("late req",   {31'b0, imem_req},  32'h1);
    chk("late addr",  imem_addr,           32'h400000);
    chk("late valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("late valid2", {31'b0, out_valid}, 32'h0);
    chk("late req2",   {31'b0, imem_req},  32'h1);
    imem_rvalid = 0;

    // PC wrap-around on the second instance
    #2 w_rst = 0;
    @(posedge clk); #1;
    chk("wrap req0",  {31'b0, w_req}, 32'h1);
    chk("wrap addr0", w_addr,          32'hFFFF_FFFC);
    w_gnt = 1;
    @(posedge clk); #1;
    w_gnt = 0; w_rvalid = 1; w_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("wrap valid", {31'b0, w_ov}, 32'h1);
    chk("wrap pc",    w_pc,           32'hFFFF_FFFC);
    chk("wrap pc4",   w_pc4,          32'h0000_0000);
    chk("wrap instr", w_instr,        32'h1234_5678);
    w_rvalid = 0; w_ready = 1;
    @(posedge clk); #1;
    chk("wrap req1",  {31'b0, w_req}, 32'h1);
    chk("wrap addr1", w_addr,          32'h0000_0000);
    w_ready = 0; w_gnt = 1;
    @(posedge clk); #1;
    w_gnt = 0; w_rvalid = 1; w_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    chk("wrap pc b",  w_pc,  32'h0000_0000);
    chk("wrap pc4 b", w_pc4, 32'h0000_0004);
    w_rvalid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
